// File: rtl/aes_out_serializer.sv
// Cipher-block FIFO feeding an MSW-first word serializer with valid/ready output and a sticky overflow flag.
// Optional build macro AES_SER_BSWAP_EN byte-reverses every output word.
module aes_out_serializer #(
  parameter int DATA_W     = 128,
  parameter int WORD_W     = 32,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          valid_in,
  input  logic [DATA_W-1:0]             cipher_text,
  input  logic                          ovf_clr,
  output logic                          word_valid,
  input  logic                          word_ready,
  output logic [WORD_W-1:0]             word_data,
  output logic                          word_last,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
  output logic                          overflow
);

  localparam int NW = DATA_W / WORD_W;
  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int IW = (NW > 1) ? $clog2(NW) : 1;

  typedef enum logic {IDLE, SEND} state_t;

  state_t              state, state_nxt;
  logic [PW:0]         wr_ptr, rd_ptr, level;
  logic                full, empty, push, pop, drop, xfer, is_last;
  logic [DATA_W-1:0]   mem [FIFO_DEPTH];
  logic [DATA_W-1:0]   shreg;
  logic [IW-1:0]       idx;
  logic [WORD_W-1:0]   word_raw;

  // The extra pointer bit makes the difference span 0..FIFO_DEPTH, so full and empty never alias.
  assign level   = wr_ptr - rd_ptr;
  assign full    = (level == (PW+1)'(FIFO_DEPTH));
  assign empty   = (level == '0);
  assign is_last = (idx == IW'(NW - 1));
  assign xfer    = word_valid && word_ready;
  assign push    = valid_in && (!full || pop);
  assign drop    = valid_in && full && !pop;

  always_comb begin
    // NOTE: every combinational output gets a default first, so no path through the case can infer a latch.
    state_nxt  = state;
    word_valid = 1'b0;
    pop        = 1'b0;
    case (state)
      IDLE: begin
        if (!empty) begin
          pop       = 1'b1;
          state_nxt = SEND;
        end
      end
      SEND: begin
        word_valid = 1'b1;
        if (word_ready && is_last) begin
          if (!empty) pop       = 1'b1;
          else        state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state    <= IDLE;
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      idx      <= '0;
      overflow <= 1'b0;
    end else begin
      state <= state_nxt;
      if (push) wr_ptr <= wr_ptr + (PW+1)'(1);
      if (pop)  rd_ptr <= rd_ptr + (PW+1)'(1);
      if (pop)                   idx <= '0;
      else if (xfer && !is_last) idx <= idx + IW'(1);
      // A drop in the same cycle as a clear must leave the flag set.
      if (drop)         overflow <= 1'b1;
      else if (ovf_clr) overflow <= 1'b0;
    end
  end

  // NOTE: block storage and the shift register carry no reset; output gating hides their power-up contents.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr[PW-1:0]] <= cipher_text;
    if (pop)       shreg <= mem[rd_ptr[PW-1:0]];
    else if (xfer) shreg <= shreg << WORD_W;
  end

  assign word_raw = shreg[DATA_W-1 -: WORD_W];

`ifdef AES_SER_BSWAP_EN
  function automatic logic [WORD_W-1:0] bswap(input logic [WORD_W-1:0] w);
    logic [WORD_W-1:0] r;
    r = '0;
    for (int b = 0; b < WORD_W / 8; b++) r[WORD_W-1-8*b -: 8] = w[8*b +: 8];
    return r;
  endfunction
  assign word_data = (state == SEND) ? bswap(word_raw) : '0;
`else
  assign word_data = (state == SEND) ? word_raw : '0;
`endif

  assign word_last  = (state == SEND) && is_last;
  assign fifo_level = level;

endmodule
